// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - states, opcode/funct constants and ALU encodings for the multicycle controller (MC_CTRL_JUMP_EN adds JUMP)
package mc_ctrl_pkg;

    localparam int OPW_DEF   = 6;
    localparam int FNW_DEF   = 6;
    localparam int ALUCW_DEF = 3;
    localparam int STW_DEF   = 4;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        RTEX   = 4'd6,
        RTWB   = 4'd7,
        BEQ    = 4'd8,
        ADDIEX = 4'd9,
`ifdef MC_CTRL_JUMP_EN
        ADDIWB = 4'd10,
        JUMP   = 4'd11
`else
        ADDIWB = 4'd10
`endif
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALUC_ADD = 3'b010;
    localparam logic [2:0] ALUC_SUB = 3'b110;
    localparam logic [2:0] ALUC_AND = 3'b000;
    localparam logic [2:0] ALUC_OR  = 3'b001;
    localparam logic [2:0] ALUC_SLT = 3'b111;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - controller <-> datapath signal bundle
interface multicycle_ctrl_if #(
    parameter int OPW   = 6,
    parameter int FNW   = 6,
    parameter int ALUCW = 3,
    parameter int STW   = 4
);
    logic [OPW-1:0]   opcode;
    logic [FNW-1:0]   funct;
    logic             zero;
    logic             PCEn;
    logic             IorD;
    logic             MemWrite;
    logic             IRWrite;
    logic             RegDst;
    logic             MemtoReg;
    logic             RegWrite;
    logic             ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [ALUCW-1:0] ALUControl;
    logic [1:0]       PCSrc;
    logic             illegal;
    logic             instr_done;
    logic [STW-1:0]   state_o;

    modport master (
        input  opcode, funct, zero,
        output PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, ALUControl, PCSrc, illegal, instr_done, state_o
    );

    modport slave (
        output opcode, funct, zero,
        input  PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, ALUControl, PCSrc, illegal, instr_done, state_o
    );
endinterface

// File: rtl/multicycle_ctrl_alu_decoder.sv
// rtl/multicycle_ctrl_alu_decoder.sv - ALUOp + funct to ALUControl; funct_valid flags supported R-type functs
module alu_decoder
    import mc_ctrl_pkg::*;
#(
    parameter int FNW   = 6,
    parameter int ALUCW = 3
) (
    input  aluop_t           aluop,
    input  logic [FNW-1:0]   funct,
    output logic [ALUCW-1:0] alu_ctrl,
    output logic             funct_valid
);
    logic [2:0] fn_ctrl;

    always_comb begin
        fn_ctrl     = ALUC_ADD;
        funct_valid = 1'b1;
        case (funct)
            FNW'(FN_ADD): fn_ctrl = ALUC_ADD;
            FNW'(FN_SUB): fn_ctrl = ALUC_SUB;
            FNW'(FN_AND): fn_ctrl = ALUC_AND;
            FNW'(FN_OR):  fn_ctrl = ALUC_OR;
            FNW'(FN_SLT): fn_ctrl = ALUC_SLT;
            default:      funct_valid = 1'b0;
        endcase
    end

    always_comb begin
        alu_ctrl = ALUCW'(ALUC_ADD);
        case (aluop)
            ALUOP_SUB:   alu_ctrl = ALUCW'(ALUC_SUB);
            ALUOP_FUNCT: alu_ctrl = ALUCW'(fn_ctrl);
            default:     alu_ctrl = ALUCW'(ALUC_ADD);
        endcase
    end
endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - Moore main controller for the multicycle MIPS datapath; MC_CTRL_JUMP_EN enables j
module multicycle_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int OPW   = 6,
    parameter int FNW   = 6,
    parameter int ALUCW = 3,
    parameter int STW   = 4
) (
    input logic            clk,
    input logic            rst,
    multicycle_ctrl_if.master bus
);
    state_t           state_q, state_d;
    aluop_t           aluop;
    logic             alu_used;
    logic [ALUCW-1:0] alu_ctrl;
    logic             funct_valid;
    logic             pc_write, branch;
    logic             iord, mem_write, ir_write, reg_dst, memto_reg, reg_write, alusrc_a;
    logic [1:0]       alusrc_b, pc_src;
    logic             illegal, instr_done;

    alu_decoder #(.FNW(FNW), .ALUCW(ALUCW)) u_alu_dec (
        .aluop       (aluop),
        .funct       (bus.funct),
        .alu_ctrl    (alu_ctrl),
        .funct_valid (funct_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d    = FETCH;
        aluop      = ALUOP_ADD;
        alu_used   = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;
        iord       = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        memto_reg  = 1'b0;
        reg_write  = 1'b0;
        alusrc_a   = 1'b0;
        alusrc_b   = 2'b00;
        pc_src     = 2'b00;
        illegal    = 1'b0;
        instr_done = 1'b0;
        case (state_q)
            FETCH: begin
                ir_write = 1'b1; alusrc_b = 2'b01; alu_used = 1'b1; pc_write = 1'b1;
                state_d  = DECODE;
            end
            DECODE: begin
                alusrc_b = 2'b10; alu_used = 1'b1;
                case (bus.opcode)
                    OPW'(OP_LW), OPW'(OP_SW): state_d = MEMADR;
                    OPW'(OP_RTYPE): begin
                        if (funct_valid) state_d = RTEX;
                        else             illegal = 1'b1;
                    end
                    OPW'(OP_BEQ):  state_d = BEQ;
                    OPW'(OP_ADDI): state_d = ADDIEX;
`ifdef MC_CTRL_JUMP_EN
                    OPW'(OP_J):    state_d = JUMP;
`endif
                    default:       illegal = 1'b1;
                endcase
            end
            MEMADR: begin
                alusrc_a = 1'b1; alusrc_b = 2'b10; alu_used = 1'b1;
                state_d  = (bus.opcode == OPW'(OP_SW)) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                iord = 1'b1; state_d = MEMWB;
            end
            MEMWB: begin
                memto_reg = 1'b1; reg_write = 1'b1; instr_done = 1'b1;
            end
            MEMWR: begin
                iord = 1'b1; mem_write = 1'b1; instr_done = 1'b1;
            end
            RTEX: begin
                alusrc_a = 1'b1; aluop = ALUOP_FUNCT; alu_used = 1'b1; state_d = RTWB;
            end
            RTWB: begin
                reg_dst = 1'b1; reg_write = 1'b1; instr_done = 1'b1;
            end
            BEQ: begin
                alusrc_a = 1'b1; aluop = ALUOP_SUB; alu_used = 1'b1;
                pc_src   = 2'b01; branch = 1'b1; instr_done = 1'b1;
            end
            ADDIEX: begin
                alusrc_a = 1'b1; alusrc_b = 2'b10; alu_used = 1'b1; state_d = ADDIWB;
            end
            ADDIWB: begin
                reg_write = 1'b1; instr_done = 1'b1;
            end
`ifdef MC_CTRL_JUMP_EN
            JUMP: begin
                pc_src = 2'b10; pc_write = 1'b1; instr_done = 1'b1;
            end
`endif
            default: state_d = FETCH;
        endcase
    end

    // Reset forces every output low even though the state register already reads FETCH.
    assign bus.PCEn       = ~rst & (pc_write | (branch & bus.zero));
    assign bus.IorD       = ~rst & iord;
    assign bus.MemWrite   = ~rst & mem_write;
    assign bus.IRWrite    = ~rst & ir_write;
    assign bus.RegDst     = ~rst & reg_dst;
    assign bus.MemtoReg   = ~rst & memto_reg;
    assign bus.RegWrite   = ~rst & reg_write;
    assign bus.ALUSrcA    = ~rst & alusrc_a;
    assign bus.ALUSrcB    = rst ? 2'b00 : alusrc_b;
    assign bus.ALUControl = (rst || !alu_used) ? '0 : alu_ctrl;
    assign bus.PCSrc      = rst ? 2'b00 : pc_src;
    assign bus.illegal    = ~rst & illegal;
    assign bus.instr_done = ~rst & instr_done;
    assign bus.state_o    = STW'(state_q);
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD = 4'd3,
                           S_MEMWB = 4'd4, S_MEMWR = 4'd5, S_RTEX = 4'd6, S_RTWB = 4'd7,
                           S_BEQ = 4'd8, S_ADDIEX = 4'd9, S_ADDIWB = 4'd10, S_JUMP = 4'd11;

    multicycle_ctrl_if #(.OPW(6), .FNW(6), .ALUCW(3), .STW(4)) bus ();

    multicycle_ctrl #(.OPW(6), .FNW(6), .ALUCW(3), .STW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // {PCEn,IorD,MemWrite,IRWrite,RegWrite,illegal,instr_done}
    function automatic logic [6:0] strobes();
        return {bus.PCEn, bus.IorD, bus.MemWrite, bus.IRWrite, bus.RegWrite, bus.illegal, bus.instr_done};
    endfunction

    task automatic check_fetch(input string tag);
        chk({tag, ".state"}, bus.state_o, S_FETCH);
        chk({tag, ".strobes"}, strobes(), 7'b1001000);
        chk({tag, ".srcb"}, bus.ALUSrcB, 2'b01);
        chk({tag, ".aluc"}, bus.ALUControl, 3'b010);
    endtask

    task automatic check_decode(input string tag);
        chk({tag, ".dec_state"}, bus.state_o, S_DECODE);
        chk({tag, ".dec_srcb"}, bus.ALUSrcB, 2'b10);
    endtask

    initial begin
        rst = 1'b1;
        bus.opcode = 6'b100011;
        bus.funct  = 6'b000000;
        bus.zero   = 1'b0;
        #2;
        chk("rst.state", bus.state_o, S_FETCH);
        chk("rst.strobes", strobes(), 7'b0);
        chk("rst.muxes", {bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl, bus.PCSrc, bus.RegDst, bus.MemtoReg}, 0);
        step();
        rst = 1'b0;
        #1;
        check_fetch("fetch0");

        // lw: 5 states
        step(); check_decode("lw");
        step();
        chk("lw.madr_state", bus.state_o, S_MEMADR);
        chk("lw.madr_srca", bus.ALUSrcA, 1'b1);
        chk("lw.madr_strobes", strobes(), 7'b0);
        step();
        chk("lw.rd_state", bus.state_o, S_MEMRD);
        chk("lw.rd_strobes", strobes(), 7'b0100000);
        chk("lw.rd_m2r", bus.MemtoReg, 1'b0);
        step();
        chk("lw.wb_state", bus.state_o, S_MEMWB);
        chk("lw.wb_strobes", strobes(), 7'b0000101);
        chk("lw.wb_m2r_dst", {bus.MemtoReg, bus.RegDst}, 2'b10);
        step(); check_fetch("lw.end");

        // reset in the middle of MEMRD
        step(); step(); step();
        chk("rst2.pre", bus.state_o, S_MEMRD);
        rst = 1'b1;
        #1;
        chk("rst2.state", bus.state_o, S_FETCH);
        chk("rst2.strobes", strobes(), 7'b0);
        step();
        chk("rst2.hold", {bus.state_o, strobes()}, {S_FETCH, 7'b0});
        rst = 1'b0;
        #1;
        check_fetch("rst2.release");

        // R-type sub
        bus.opcode = 6'b000000; bus.funct = 6'b100010;
        step(); check_decode("sub");
        step();
        chk("sub.ex_state", bus.state_o, S_RTEX);
        chk("sub.ex_aluc", bus.ALUControl, 3'b110);
        chk("sub.ex_src", {bus.ALUSrcA, bus.ALUSrcB}, 3'b100);
        step();
        chk("sub.wb_state", bus.state_o, S_RTWB);
        chk("sub.wb_strobes", strobes(), 7'b0000101);
        chk("sub.wb_dst", {bus.RegDst, bus.MemtoReg}, 2'b10);
        step(); check_fetch("sub.end");

        // R-type slt
        bus.funct = 6'b101010;
        step(); step();
        chk("slt.aluc", bus.ALUControl, 3'b111);
        step(); step(); check_fetch("slt.end");

        // beq taken
        bus.opcode = 6'b000100; bus.zero = 1'b1;
        step(); check_decode("beq1");
        step();
        chk("beq1.state", bus.state_o, S_BEQ);
        chk("beq1.strobes", strobes(), 7'b1000001);
        chk("beq1.pcsrc_aluc", {bus.PCSrc, bus.ALUControl}, {2'b01, 3'b110});
        step(); check_fetch("beq1.end");

        // beq not taken
        bus.zero = 1'b0;
        step(); step();
        chk("beq0.state", bus.state_o, S_BEQ);
        chk("beq0.strobes", strobes(), 7'b0000001);
        step(); check_fetch("beq0.end");

        // sw
        bus.opcode = 6'b101011;
        step(); step();
        chk("sw.madr", bus.state_o, S_MEMADR);
        step();
        chk("sw.wr_state", bus.state_o, S_MEMWR);
        chk("sw.wr_strobes", strobes(), 7'b0110001);
        step(); check_fetch("sw.end");

        // addi
        bus.opcode = 6'b001000;
        step(); step();
        chk("addi.ex", {bus.state_o, bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl}, {S_ADDIEX, 1'b1, 2'b10, 3'b010});
        step();
        chk("addi.wb_state", bus.state_o, S_ADDIWB);
        chk("addi.wb_strobes", strobes(), 7'b0000101);
        chk("addi.wb_dst", {bus.RegDst, bus.MemtoReg}, 2'b00);
        step(); check_fetch("addi.end");

        // illegal opcode
        bus.opcode = 6'b111111;
        step();
        chk("ill_op.state", bus.state_o, S_DECODE);
        chk("ill_op.strobes", strobes(), 7'b0000010);
        step(); check_fetch("ill_op.end");

        // illegal R-type funct
        bus.opcode = 6'b000000; bus.funct = 6'b000000;
        step();
        chk("ill_fn.strobes", strobes(), 7'b0000010);
        step(); check_fetch("ill_fn.end");

        // jump
        bus.opcode = 6'b000010;
        step();
`ifdef MC_CTRL_JUMP_EN
        chk("j.dec_strobes", strobes(), 7'b0);
        step();
        chk("j.state", bus.state_o, S_JUMP);
        chk("j.strobes", strobes(), 7'b1000001);
        chk("j.pcsrc", bus.PCSrc, 2'b10);
        step(); check_fetch("j.end");
`else
        chk("j.illegal", strobes(), 7'b0000010);
        chk("j.pcsrc", bus.PCSrc, 2'b00);
        step(); check_fetch("j.end");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
